onehot_stream_decoder: RTL and testbench

- Parametrised, registered successor to the 4-to-16 one-hot decoder.
- Decodes a W-bit select code into a 2**W-bit one-hot word behind a valid/ready handshake.
- Adds an autonomous SCAN mode that walks the hot bit across all outputs with a programmable dwell time.
- Drives row/LED/chip-select style fan-out in the CA datapath, where downstream logic may stall.

---
 rtl/onehot_pkg.sv | 17 +
 rtl/onehot_map.sv | 17 +
 rtl/onehot_stream_decoder.sv | 140 ++++++++++++++
 tb/tb_onehot_stream_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared state/mode types, counter width and code-to-bit-index mapping
package onehot_pkg;

    typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

    typedef enum logic {MODE_DECODE = 1'b0, MODE_SCAN = 1'b1} mode_t;

    localparam int DWELL_CNT_W = 8;

    // Two's-complement map sends v to N-1-(v+2**(w-1)); bitwise that keeps the sign bit and inverts the rest
    function automatic int unsigned onehot_idx(input int unsigned code, input bit signed_map, input int unsigned w = 4);
        int unsigned low_mask;
        low_mask = (32'd1 << (w - 1)) - 1;
        return signed_map ? (code ^ low_mask) : code;
    endfunction

endpackage

// File: rtl/onehot_map.sv
// onehot_map: combinational W-bit code to 2**W-bit one-hot word
module onehot_map
    import onehot_pkg::*;
#(
    parameter int W          = 4,
    parameter bit SIGNED_MAP = 1'b1
) (
    input  logic [W-1:0]    code_i,
    output logic [2**W-1:0] y_o
);

    localparam int N = 2**W;
    localparam logic [N-1:0] ONE = N'(1);

    assign y_o = ONE << onehot_idx(32'(code_i), SIGNED_MAP, W);

endmodule

// File: rtl/onehot_stream_decoder.sv
// onehot_stream_decoder: registered one-hot decoder with valid/ready handshake and autonomous SCAN mode;
// define ONEHOT_CHECK_EN to add the sticky err_o invariant monitor
module onehot_stream_decoder
    import onehot_pkg::*;
#(
    parameter int W          = 4,
    parameter bit SIGNED_MAP = 1'b1,
    parameter int DWELL      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**W-1:0] y
`ifdef ONEHOT_CHECK_EN
    ,
    output logic            err_o
`endif
);

    localparam int N = 2**W;
    localparam logic [W-1:0] IDX_TOP = W'(N - 1);
    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL - 1);

    state_t                 state_q, state_d;
    logic [N-1:0]           y_q, y_d;
    logic                   out_valid_q, out_valid_d;
    logic [DWELL_CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]           idx_q, idx_d;
    logic [N-1:0]           code_hot, scan_hot;
    logic                   step, take;
    mode_t                  mode;

    assign mode = mode_t'(mode_i);

    onehot_map #(.W(W), .SIGNED_MAP(SIGNED_MAP)) u_code_map (.code_i(w), .y_o(code_hot));

    // The scan path always shows the next index, so entering SCAN or stepping loads the right word directly
    onehot_map #(.W(W), .SIGNED_MAP(1'b0)) u_scan_map (.code_i(idx_d), .y_o(scan_hot));

    // Dwell counter and scan index: frozen while stalled, parked at the top bit whenever not scanning
    always_comb begin
        step  = (state_q == SCAN) && out_ready && (cnt_q == DWELL_LAST);
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (state_q != SCAN || (step && mode == MODE_DECODE)) begin
            cnt_d = '0;
            idx_d = IDX_TOP;
        end else if (out_ready) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
            idx_d = step ? idx_q - 1'b1 : idx_q;
        end
    end

    // Next state, handshake and output register; a mode change waits for the output word to drain
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        in_ready    = (state_q == DECODE) && (mode == MODE_DECODE) && (!out_valid_q || out_ready);
        take        = in_ready && in_valid;
        unique case (state_q)
            IDLE: begin
                state_d     = (mode == MODE_SCAN) ? SCAN : DECODE;
                y_d         = (mode == MODE_SCAN) ? scan_hot : '0;
                out_valid_d = (mode == MODE_SCAN);
            end
            DECODE: begin
                if (take) begin
                    y_d         = code_hot;
                    out_valid_d = 1'b1;
                end else if (out_valid_q && out_ready) begin
                    y_d         = '0;
                    out_valid_d = 1'b0;
                end else if (!out_valid_q && mode == MODE_SCAN) begin
                    state_d     = SCAN;
                    y_d         = scan_hot;
                    out_valid_d = 1'b1;
                end
            end
            SCAN: begin
                state_d     = (step && mode == MODE_DECODE) ? IDLE : SCAN;
                y_d         = (step && mode == MODE_DECODE) ? '0 : scan_hot;
                out_valid_d = !(step && mode == MODE_DECODE);
            end
            default: begin
                state_d     = IDLE;
                y_d         = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= IDX_TOP;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

`ifdef ONEHOT_CHECK_EN
    logic err_q, err_d, bad;

    // A registered word with more than one hot bit, or valid with no hot bit, is an invariant breach
    always_comb begin
        bad   = ($countones(y_q) > 1) || (out_valid_q && y_q == '0);
        err_d = err_q || bad;
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            assert (!bad);
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// tb_onehot_stream_decoder: directed literal checks plus randomized run against a behavioural model
module tb_onehot_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        iv = 1'b0;
    logic [3:0]  w = 4'd0;
    logic        ordy = 1'b1;
    logic [15:0] y0, y1;
    logic        ov0, ov1, ir0, ir1;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;

    int ph[2];
    int have[2];
    int widx[2];
    int pos[2];
    int cnt[2];

`ifdef ONEHOT_CHECK_EN
    logic err0, err1;
`endif

    onehot_stream_decoder #(.W(4), .SIGNED_MAP(1'b1), .DWELL(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .in_valid(iv), .in_ready(ir0),
        .w(w), .out_valid(ov0), .out_ready(ordy), .y(y0)
`ifdef ONEHOT_CHECK_EN
        , .err_o(err0)
`endif
    );

    onehot_stream_decoder #(.W(4), .SIGNED_MAP(1'b0), .DWELL(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .in_valid(iv), .in_ready(ir1),
        .w(w), .out_valid(ov1), .out_ready(ordy), .y(y1)
`ifdef ONEHOT_CHECK_EN
        , .err_o(err1)
`endif
    );

    always #5 clk = ~clk;

    function automatic int map_idx(input int code, input int k);
        int v;
        if (k != 0) return code;
        v = (code >= 8) ? code - 16 : code;
        return 15 - (v + 8);
    endfunction

    function automatic logic [15:0] exp_y(input int k);
        logic [15:0] one;
        one = 16'd1;
        if (ph[k] == 2) return one << pos[k];
        if (ph[k] == 1 && have[k] != 0) return one << widx[k];
        return 16'd0;
    endfunction

    function automatic logic exp_ir(input int k);
        return (ph[k] == 1) && !mode && (have[k] == 0 || ordy);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model phases: 0 idle, 1 decode, 2 scan; advanced on each edge from the inputs seen at that edge
    task automatic model_step(input int k);
        int dw;
        dw = (k == 0) ? 4 : 2;
        if (!rst_n) begin
            ph[k] = 0; have[k] = 0; pos[k] = 15; cnt[k] = 0;
        end else if (ph[k] == 0) begin
            ph[k] = mode ? 2 : 1; pos[k] = 15; cnt[k] = 0;
        end else if (ph[k] == 1) begin
            if (mode && have[k] == 0) begin
                ph[k] = 2; pos[k] = 15; cnt[k] = 0;
            end else if (!mode && iv && (have[k] == 0 || ordy)) begin
                have[k] = 1; widx[k] = map_idx(int'(w), k);
            end else if (have[k] != 0 && ordy) begin
                have[k] = 0;
            end
        end else if (ordy) begin
            if (cnt[k] == dw - 1) begin
                cnt[k] = 0;
                if (!mode) ph[k] = 0;
                else pos[k] = (pos[k] + 15) % 16;
            end else begin
                cnt[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("y0", 32'(y0), 32'(exp_y(0)));
            check("out_valid0", 32'(ov0), 32'(exp_y(0) != 16'd0));
            check("in_ready0", 32'(ir0), 32'(exp_ir(0)));
            check("y1", 32'(y1), 32'(exp_y(1)));
            check("out_valid1", 32'(ov1), 32'(exp_y(1) != 16'd0));
            check("in_ready1", 32'(ir1), 32'(exp_ir(1)));
`ifdef ONEHOT_CHECK_EN
            check("err0", 32'(err0), 32'd0);
            check("err1", 32'(err1), 32'd0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        chk_en = 1'b1;
        check("reset_y", 32'(y0), 32'h0);
        check("reset_out_valid", 32'(ov0), 32'h0);
        check("reset_in_ready", 32'(ir0), 32'h0);
        rst_n = 1'b1;
        cyc();
        check("decode_ready", 32'(ir0), 32'h1);
        iv = 1'b1; w = 4'b1000;
        cyc();
        check("code_1000", 32'(y0), 32'h8000);
        check("code_1000_valid", 32'(ov0), 32'h1);
        w = 4'b0000;
        cyc();
        check("code_0000", 32'(y0), 32'h0080);
        check("code_0000_binary", 32'(y1), 32'h0001);
        w = 4'b0111;
        cyc();
        check("code_0111", 32'(y0), 32'h0001);
        w = 4'b0011;
        cyc();
        check("code_0011_binary", 32'(y1), 32'h0008);
        check("code_0011_signed", 32'(y0), 32'h0010);
        iv = 1'b0;
        cyc();
        check("drain_valid", 32'(ov0), 32'h0);
        check("drain_y", 32'(y0), 32'h0);
        iv = 1'b1; w = 4'b1001; ordy = 1'b0;
        cyc();
        check("stall_accept", 32'(y0), 32'h4000);
        w = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_hold_y", 32'(y0), 32'h4000);
            check("stall_in_ready", 32'(ir0), 32'h0);
        end
        ordy = 1'b1;
        #1;
        check("release_in_ready", 32'(ir0), 32'h1);
        cyc();
        check("release_accept", 32'(y0), 32'h0020);
        iv = 1'b0;
        cyc();
        mode = 1'b1;
        cyc();
        for (int t = 0; t <= 64; t++) begin
            check("scan_walk", 32'(y0), 32'(16'h8000 >> ((t / 4) % 16)));
            if (t < 64) cyc();
        end
        check("scan_wrap", 32'(y0), 32'h8000);
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("scan_exit_wait", 32'(y0), 32'h8000);
        end
        cyc();
        check("scan_exit_y", 32'(y0), 32'h0);
        check("scan_exit_valid", 32'(ov0), 32'h0);
        cyc();
        mode = 1'b1;
        cyc();
        cyc();
        check("scan_again_valid", 32'(ov0), 32'h1);
        rst_n = 1'b0;
        cyc();
        check("midscan_reset_y", 32'(y0), 32'h0);
        check("midscan_reset_valid", 32'(ov0), 32'h0);
        rst_n = 1'b1; mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            iv    = 1'($urandom_range(0, 1));
            w     = 4'($urandom);
            ordy  = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
